avr_io_uart_bridge: RTL and testbench

- Serial debug master for the AVR I/O bus: receives command frames on rxd (8N1) and drives io_re/io_we/io_a/io_di as the bus initiator.
- Read data taken from io_do is returned on txd.
- Sits beside the CPU and is muxed onto the peripheral I/O bus by the top level when dbg_en is high.
- Peripherals answer exactly as they do to the CPU: combinational io_do in the io_re cycle.

---
 rtl/avr_io_uart_bridge_if.sv | 13 +
 rtl/avr_io_uart_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_avr_io_uart_bridge.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_io_uart_bridge_if.sv
// AVR peripheral I/O bus as seen by a bus initiator (master) and the peripheral side (slave).
interface avr_io_uart_bridge_if #(
    parameter int ADDR_W = 6
);
    logic              io_re;
    logic              io_we;
    logic [ADDR_W-1:0] io_a;
    logic [7:0]        io_di;
    logic [7:0]        io_do;

    modport master (output io_re, io_we, io_a, io_di, input io_do);
    modport slave  (input io_re, io_we, io_a, io_di, output io_do);
endinterface

// File: rtl/avr_io_uart_bridge.sv
// Serial (8N1) debug master for the AVR I/O bus: command/data bytes on rxd, read data back on txd.
// Optional macro AVR_BRIDGE_TIMEOUT_EN adds an inter-byte timeout while waiting for write data.
module avr_io_uart_bridge #(
    parameter int ADDR_W       = 6,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           prescaler,
    input  logic                 rxd,
    output logic                 txd,
    avr_io_uart_bridge_if.master io,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);
    if (ADDR_W < 1 || ADDR_W > 6 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("avr_io_uart_bridge: parameter out of range");
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {S_CMD, S_WDATA, S_WR, S_RD, S_TX} state_t;

    rx_state_t         rx_state;
    state_t            state;
    logic              rx_s1, rx_s2;
    logic [7:0]        rx_sub, tx_sub;
    logic [2:0]        rx_tcnt, rx_bit, tx_tcnt;
    logic [3:0]        tx_bit;
    logic [7:0]        rx_shift;
    logic [8:0]        tx_shift;
    logic              rx_valid;
    logic              io_re_q, io_we_q;
    logic [ADDR_W-1:0] io_a_q;
    logic [7:0]        io_di_q;
`ifdef AVR_BRIDGE_TIMEOUT_EN
    logic [7:0]        to_sub;
    logic [2:0]        to_tcnt;
    logic [31:0]       to_bits;
`endif

    wire rx_tick = (rx_sub == 8'd0);
    wire tx_tick = (tx_sub == 8'd0);

    assign io.io_re = io_re_q;
    assign io.io_we = io_we_q;
    assign io.io_a  = io_a_q;
    assign io.io_di = io_di_q;
    assign busy     = (state != S_CMD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    // Sub-tick phase restarts on start detection so mid-bit sampling is aligned to the falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_sub    <= '0;
            rx_tcnt   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_sub    <= rx_tick ? prescaler : rx_sub - 8'd1;
            case (rx_state)
                RX_IDLE: if (!rx_s2) begin
                    rx_state <= RX_START;
                    rx_sub   <= prescaler;
                    rx_tcnt  <= '0;
                end
                RX_START: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 3'd1;
                    if (rx_tcnt == 3'd3) begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 3'd1;
                    if (rx_tcnt == 3'd7) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: if (rx_tick) begin
                    rx_tcnt <= rx_tcnt + 3'd1;
                    if (rx_tcnt == 3'd7) begin
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_CMD;
            io_re_q  <= 1'b0;
            io_we_q  <= 1'b0;
            io_a_q   <= '0;
            io_di_q  <= '0;
            txd      <= 1'b1;
            overrun  <= 1'b0;
            tx_sub   <= '0;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
`ifdef AVR_BRIDGE_TIMEOUT_EN
            to_sub   <= '0;
            to_tcnt  <= '0;
            to_bits  <= '0;
`endif
        end else begin
            io_re_q <= 1'b0;
            io_we_q <= 1'b0;
            overrun <= rx_valid && (state == S_WR || state == S_RD || state == S_TX);
            case (state)
                S_CMD: if (rx_valid && !rx_shift[6]) begin
                    io_a_q <= rx_shift[ADDR_W-1:0];
                    if (rx_shift[7]) begin
                        state <= S_WDATA;
`ifdef AVR_BRIDGE_TIMEOUT_EN
                        to_sub  <= prescaler;
                        to_tcnt <= '0;
                        to_bits <= '0;
`endif
                    end else begin
                        state   <= S_RD;
                        io_re_q <= 1'b1;
                    end
                end
                S_WDATA: if (rx_valid) begin
                    io_di_q <= rx_shift;
                    io_we_q <= 1'b1;
                    state   <= S_WR;
                end
`ifdef AVR_BRIDGE_TIMEOUT_EN
                // Timeout only advances while no start bit is being received.
                else if (rx_state == RX_IDLE) begin
                    if (to_sub == 8'd0) begin
                        to_sub  <= prescaler;
                        to_tcnt <= to_tcnt + 3'd1;
                        if (to_tcnt == 3'd7) begin
                            if (to_bits == 32'(TIMEOUT_BITS - 1)) state <= S_CMD;
                            else to_bits <= to_bits + 32'd1;
                        end
                    end else begin
                        to_sub <= to_sub - 8'd1;
                    end
                end
`endif
                S_WR: state <= S_CMD;
                S_RD: begin
                    tx_shift <= {1'b1, io.io_do};
                    txd      <= 1'b0;
                    tx_sub   <= prescaler;
                    tx_tcnt  <= '0;
                    tx_bit   <= '0;
                    state    <= S_TX;
                end
                S_TX: if (tx_tick) begin
                    tx_sub  <= prescaler;
                    tx_tcnt <= tx_tcnt + 3'd1;
                    if (tx_tcnt == 3'd7) begin
                        if (tx_bit == 4'd9) begin
                            txd   <= 1'b1;
                            state <= S_CMD;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end
                end else begin
                    tx_sub <= tx_sub - 8'd1;
                end
                default: state <= S_CMD;
            endcase
        end
    end
endmodule

// File: tb/tb_avr_io_uart_bridge.sv
// Directed + randomized bench for avr_io_uart_bridge with a memory-level reference model.
module tb_avr_io_uart_bridge;
    localparam int ADDR_W = 6;
`ifdef AVR_BRIDGE_TIMEOUT_EN
    localparam int TO_BITS = 4;
`else
    localparam int TO_BITS = 32;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] prescaler = 8'd0;
    logic       rxd = 1'b1;
    logic       txd, busy, frame_err, overrun;

    avr_io_uart_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    avr_io_uart_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk(clk), .rst(rst), .prescaler(prescaler), .rxd(rxd), .txd(txd),
        .io(bus), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] periph [64];
    logic [7:0] ref_mem [64];
    assign bus.io_do = periph[bus.io_a];
    always @(posedge clk) if (bus.io_we) periph[bus.io_a] <= bus.io_di;

    int we_cnt = 0, re_cnt = 0, both_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int we_cyc = 0, re_cyc = 0, we_addr = 0, re_addr = 0, we_data = 0;
    always @(negedge clk) begin
        if (bus.io_we) begin
            we_cnt++; we_cyc = cyc; we_addr = int'(bus.io_a); we_data = int'(bus.io_di);
        end
        if (bus.io_re) begin
            re_cnt++; re_cyc = cyc; re_addr = int'(bus.io_a);
        end
        if (bus.io_we && bus.io_re) both_cnt++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    logic [7:0] txq [$];
    logic       frmq [$];
    int         tx_start = 0;
    logic       tx_active = 1'b0;
    initial begin : tx_decoder
        int bp;
        logic [7:0] b;
        logic st, sb;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                tx_start = cyc; tx_active = 1'b1;
                bp = 8 * (int'(prescaler) + 1);
                repeat (bp / 2) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (bp) @(negedge clk);
                    b[i] = txd;
                end
                repeat (bp) @(negedge clk);
                sb = txd;
                txq.push_back(b);
                frmq.push_back(sb === 1'b1 && st === 1'b0);
                tx_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe cycle derived from the frame's start edge: 2-flop sync, detection, 76 sub-ticks to stop sample, +1.
    function automatic logic in_win(input int c, input int k, input int p);
        int e;
        e = k + 4 + 76 * (p + 1);
        return (c <= e) && (c >= e - p);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len, output int k);
        int bp;
        bp = 8 * (int'(prescaler) + 1);
        @(negedge clk);
        rxd = 1'b0; k = cyc;
        tick(bp);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(bp);
        end
        rxd = stop_bit;
        tick(stop_len);
        rxd = 1'b1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input string tag);
        int k0, k1, we0, re0, p, bp;
        we0 = we_cnt; re0 = re_cnt; p = int'(prescaler); bp = 8 * (p + 1);
        send_byte({2'b10, a}, 1'b1, bp, k0);
        send_byte(d, 1'b1, bp, k1);
        tick(bp);
        chk({tag, "_we_cycles"}, we_cnt - we0, 1);
        chk({tag, "_no_re"}, re_cnt - re0, 0);
        chk({tag, "_addr"}, we_addr, int'(a));
        chk({tag, "_data"}, we_data, int'(d));
        chk({tag, "_timing"}, 32'(in_win(we_cyc, k1, p)), 1);
        chk({tag, "_busy_idle"}, 32'(busy), 0);
        chk({tag, "_no_tx"}, txq.size(), 0);
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [5:0] a, input string tag);
        int k, we0, re0, p, bp, n;
        we0 = we_cnt; re0 = re_cnt; p = int'(prescaler); bp = 8 * (p + 1);
        send_byte({2'b00, a}, 1'b1, bp, k);
        n = 0;
        while (txq.size() == 0 && n < 30 * bp) begin tick(1); n++; end
        chk({tag, "_resp_count"}, txq.size(), 1);
        if (txq.size() > 0) begin
            chk({tag, "_resp_data"}, 32'(txq.pop_front()), 32'(ref_mem[a]));
            chk({tag, "_resp_framing"}, 32'(frmq.pop_front()), 1);
        end
        n = 0;
        while (busy && n < 4 * bp) begin tick(1); n++; end
        chk({tag, "_busy_drop"}, cyc - tx_start, 80 * (p + 1));
        chk({tag, "_re_cycles"}, re_cnt - re0, 1);
        chk({tag, "_no_we"}, we_cnt - we0, 0);
        chk({tag, "_addr"}, re_addr, int'(a));
        chk({tag, "_re_timing"}, 32'(in_win(re_cyc, k, p)), 1);
        chk({tag, "_start_after_re"}, tx_start - re_cyc, 1);
    endtask

    initial begin : stimulus
        int k, k2, n, bp, we0, re0, fe0, ov0, op;
        logic [7:0] v, cmd;
        logic [5:0] a;

        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            periph[i] = v; ref_mem[i] = v;
        end
        periph[3] = 8'hA7; ref_mem[3] = 8'hA7;

        rst = 1'b1;
        tick(4);
        chk("rst_txd", 32'(txd), 1);
        chk("rst_io_re", 32'(bus.io_re), 0);
        chk("rst_io_we", 32'(bus.io_we), 0);
        chk("rst_io_a", 32'(bus.io_a), 0);
        chk("rst_io_di", 32'(bus.io_di), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        tick(4);

        prescaler = 8'd0;
        do_write(6'h0A, 8'h5C, "wr0a");
        do_read(6'h03, "rd03");

        prescaler = 8'd3; bp = 32;
        we0 = we_cnt; re0 = re_cnt;
        send_byte(8'h45, 1'b1, bp, k);
        tick(bp);
        chk("rsv_no_strobe", (we_cnt - we0) + (re_cnt - re0), 0);
        chk("rsv_busy", 32'(busy), 0);
        do_read(6'h01, "rd01");

        we0 = we_cnt; re0 = re_cnt; fe0 = fe_cnt;
        send_byte(8'h8A, 1'b0, bp, k);
        tick(bp);
        chk("ferr_pulse", fe_cnt - fe0, 1);
        chk("ferr_no_strobe", (we_cnt - we0) + (re_cnt - re0), 0);
        chk("ferr_busy", 32'(busy), 0);
        do_write(6'h0A, 8'h11, "wr_after_ferr");

        // Short stop bit on the command so the second byte lands while the response is still sending.
        re0 = re_cnt; we0 = we_cnt; ov0 = ov_cnt;
        send_byte(8'h02, 1'b1, 5 * 4, k);
        send_byte(8'h81, 1'b1, bp, k2);
        n = 0;
        while ((busy || txq.size() == 0) && n < 20 * bp) begin tick(1); n++; end
        chk("ovr_pulse", ov_cnt - ov0, 1);
        chk("ovr_re_once", re_cnt - re0, 1);
        chk("ovr_no_we", we_cnt - we0, 0);
        chk("ovr_resp_count", txq.size(), 1);
        if (txq.size() > 0) chk("ovr_resp_data", 32'(txq.pop_front()), 32'(ref_mem[2]));
        frmq.delete();
        tick(bp);
        chk("ovr_busy_after", 32'(busy), 0);

        send_byte(8'h02, 1'b1, bp, k);
        n = 0;
        while (!tx_active && n < 20 * bp) begin tick(1); n++; end
        chk("rstmid_tx_started", 32'(tx_active), 1);
        tick(3 * bp);
        rst = 1'b1;
        #1;
        chk("rstmid_txd", 32'(txd), 1);
        chk("rstmid_busy", 32'(busy), 0);
        tick(3);
        rst = 1'b0;
        tick(12 * bp);
        txq.delete(); frmq.delete();
        chk("rstmid_txd_idle", 32'(txd), 1);

        prescaler = 8'd0;
        we0 = we_cnt; re0 = re_cnt; fe0 = fe_cnt;
        @(negedge clk); rxd = 1'b0;
        tick(2); rxd = 1'b1;
        tick(24);
        chk("glitch_nothing", (we_cnt - we0) + (re_cnt - re0) + (fe_cnt - fe0), 0);
        chk("glitch_busy", 32'(busy), 0);

        for (int t = 0; t < 10; t++) begin
            prescaler = 8'($urandom_range(0, 3));
            bp = 8 * (int'(prescaler) + 1);
            op = $urandom_range(0, 2);
            a = 6'($urandom_range(0, 63));
            v = 8'($urandom);
            if (op == 0) do_write(a, v, $sformatf("rnd%0d_wr", t));
            else if (op == 1) do_read(a, $sformatf("rnd%0d_rd", t));
            else begin
                we0 = we_cnt; re0 = re_cnt;
                cmd = {1'($urandom), 1'b1, a};
                send_byte(cmd, 1'b1, bp, k);
                tick(bp);
                chk($sformatf("rnd%0d_rsv_ignored", t), (we_cnt - we0) + (re_cnt - re0), 0);
                chk($sformatf("rnd%0d_rsv_busy", t), 32'(busy), 0);
            end
        end

`ifdef AVR_BRIDGE_TIMEOUT_EN
        prescaler = 8'd0;
        we0 = we_cnt;
        send_byte(8'h85, 1'b1, 8, k);
        tick(8);
        chk("to_waiting", 32'(busy), 1);
        tick(32);
        chk("to_expired", 32'(busy), 0);
        chk("to_no_we", we_cnt - we0, 0);
        do_read(6'h15, "to_rd15");
`endif

        chk("never_both_strobes", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
